// File: rtl/matrix_scan_pkg.sv
// matrix_scan_pkg: shared geometry, row-index type, scan FSM states and
// the packed red/green row format used by the frame buffers.
package matrix_scan_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 8;
  localparam int ROW_W = $clog2(ROWS);

  typedef logic [ROW_W-1:0] row_idx_t;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  typedef struct packed {
    logic [COLS-1:0] red;
    logic [COLS-1:0] green;
  } pixel_row_t;

endpackage

// File: rtl/matrix_scan_if.sv
// matrix_scan_if: host-side write port and buffer-swap handshake.
// The host (master) writes rows into the back buffer and requests swaps;
// the scanner (slave) acknowledges when the swap takes effect.
interface matrix_scan_if;
  import matrix_scan_pkg::*;

  logic            wr_en;
  row_idx_t        wr_row;
  logic [COLS-1:0] wr_red;
  logic [COLS-1:0] wr_green;
  logic            swap_req;
  logic            swap_ack;

  modport master (
    output wr_en, wr_row, wr_red, wr_green, swap_req,
    input  swap_ack
  );

  modport slave (
    input  wr_en, wr_row, wr_red, wr_green, swap_req,
    output swap_ack
  );

endinterface

// File: rtl/matrix_scan_timer.sv
// scan_timer: row-period prescaler. Counts CLK_DIV cycles per row and flags
// the last cycle of the row plus look-ahead blank/last information so the
// scanner can register its outputs for the upcoming cycle.
module scan_timer #(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  output logic row_tick,
  output logic blank_next,
  output logic last_next
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Derive row end and the blank/last status of the following cycle.
  always_comb begin
    row_tick   = (cnt == LAST_CNT);
    cnt_next   = row_tick ? '0 : cnt + 1'b1;
    blank_next = (cnt_next < BLANK_END);
    last_next  = (cnt_next == LAST_CNT);
  end

  // Position within the current row period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt <= '0;
    else       cnt <= cnt_next;
  end

endmodule

// File: rtl/matrix_scan.sv
// matrix_scan: 8x8 red/green LED matrix scanner with double-buffered frames.
// Writes land in the back buffer; a requested swap is applied only at the
// frame boundary so a frame is always shown from a single buffer.
// Optional feature macro MATRIX_SCAN_DIM_EN adds a dim[2:0] input and a
// 3-bit PWM brightness gate on the drive phase.
module matrix_scan
  import matrix_scan_pkg::*;
#(
  parameter int CLK_DIV   = 1000,
  parameter int BLANK_CYC = 16
) (
  input  logic             clk,
  input  logic             reset,
  matrix_scan_if.slave     bus,
`ifdef MATRIX_SCAN_DIM_EN
  input  logic [2:0]       dim,
`endif
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  red_col,
  output logic [COLS-1:0]  green_col,
  output logic             frame_done
);

  localparam row_idx_t LAST_ROW = ROW_W'(ROWS - 1);

  logic        row_tick;
  logic        blank_next;
  logic        last_next;

  scan_state_t state;
  scan_state_t state_d;
  row_idx_t    row;
  row_idx_t    row_d;
  logic        front_sel;
  logic        front_sel_d;
  logic        pending;
  logic        pending_d;
  logic        swap_now;
  logic        lit_d;
  pixel_row_t  front_row;

  logic [ROWS-1:0] row_sel_d;
  logic [COLS-1:0] red_d;
  logic [COLS-1:0] green_d;
  logic            frame_done_d;
  logic            swap_ack_d;
  logic            swap_ack_q;

  pixel_row_t  mem [2][ROWS];

  scan_timer #(
    .CLK_DIV   (CLK_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .row_tick   (row_tick),
    .blank_next (blank_next),
    .last_next  (last_next)
  );

`ifdef MATRIX_SCAN_DIM_EN
  logic [2:0] pwm;
  logic [2:0] pwm_d;

  // Free-running PWM phase; the gate uses the value of the upcoming cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pwm <= '0;
    else       pwm <= pwm_d;
  end

  assign pwm_d = pwm + 3'd1;
  assign lit_d = (pwm_d <= dim);
`else
  assign lit_d = 1'b1;
`endif

  // Next state, swap decision and the output values for the coming cycle.
  always_comb begin
    state_d      = state;
    row_d        = row;
    front_sel_d  = front_sel;
    pending_d    = pending | bus.swap_req;
    swap_now     = 1'b0;
    swap_ack_d   = 1'b0;
    row_sel_d    = '0;
    red_d        = '0;
    green_d      = '0;
    frame_done_d = 1'b0;

    case (state)
      BLANK: if (!blank_next) state_d = DRIVE;
      DRIVE: if (row_tick)    state_d = BLANK;
    endcase

    if (row_tick) begin
      row_d    = row + 1'b1;
      swap_now = (row == LAST_ROW);
    end

    if (swap_now && pending_d) begin
      front_sel_d = ~front_sel;
      pending_d   = 1'b0;
      swap_ack_d  = 1'b1;
    end

    front_row = mem[front_sel_d][row_d];

    if (state_d == DRIVE && lit_d) begin
      row_sel_d = ROWS'(1) << row_d;
      red_d     = front_row.red;
      green_d   = front_row.green;
    end

    frame_done_d = last_next && (row_d == LAST_ROW);
  end

  // Scan position, buffer selection and registered matrix outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= BLANK;
      row        <= '0;
      front_sel  <= 1'b0;
      pending    <= 1'b0;
      row_sel    <= '0;
      red_col    <= '0;
      green_col  <= '0;
      frame_done <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      state      <= state_d;
      row        <= row_d;
      front_sel  <= front_sel_d;
      pending    <= pending_d;
      row_sel    <= row_sel_d;
      red_col    <= red_d;
      green_col  <= green_d;
      frame_done <= frame_done_d;
      swap_ack_q <= swap_ack_d;
    end
  end

  // Host writes always target the current back buffer, even on the swap edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          mem[b][r] <= '0;
        end
      end
    end else if (bus.wr_en) begin
      mem[~front_sel][bus.wr_row] <= {bus.wr_red, bus.wr_green};
    end
  end

  assign bus.swap_ack = swap_ack_q;

endmodule

// File: doc/matrix_scan.md
MATRIX_SCAN -- requirements
Module: matrix_scan

Interface
REQ-001 Parameter CLK_DIV, default 1000, clk cycles per row period; SHALL satisfy CLK_DIV > BLANK_CYC >= 1.
REQ-002 Parameter BLANK_CYC, default 16, blanking cycles at the start of each row period.
REQ-003 clk  in  1  system clock, rising-edge.
REQ-004 reset  in  1  reset, asynchronous, active-high.
REQ-005 wr_en  in  1  write strobe, one row per asserted cycle.
REQ-006 wr_row  in  3  row index 0..7 for the write.
REQ-007 wr_red  in  8  red column pattern for wr_row; bit i = column i.
REQ-008 wr_green  in  8  green column pattern for wr_row.
REQ-009 swap_req  in  1  pulse; request back/front buffer exchange.
REQ-010 swap_ack  out  1  one-cycle pulse when the swap is applied.
REQ-011 row_sel  out  8  one-hot active-high row drive; bit r = row r.
REQ-012 red_col  out  8  active-high red column drive.
REQ-013 green_col  out  8  active-high green column drive.
REQ-014 frame_done  out  1  one-cycle pulse on the last cycle of row 7.

Function
REQ-015 Two 8x16-bit buffers (front, back); the scanner reads front and writes go to back only.
REQ-016 wr_en=1 SHALL store {wr_red, wr_green} into back[wr_row] at that clk edge; same row written twice, last write wins.
REQ-017 Row counter SHALL step 0..7 and wrap to 0; each row lasts exactly CLK_DIV cycles; frame = 8*CLK_DIV cycles.
REQ-018 FSM states BLANK, DRIVE: BLANK for the first BLANK_CYC cycles of a row, DRIVE for the remaining CLK_DIV-BLANK_CYC cycles, then BLANK of the next row.
REQ-019 In BLANK: row_sel, red_col and green_col SHALL all be 0.
REQ-020 In DRIVE for row r: row_sel = 1<<r, red_col/green_col = front[r].
REQ-021 All outputs SHALL be registered; no combinational path from inputs to outputs.
REQ-022 swap_req SHALL set a pending flag; further requests while pending merge into it.
REQ-023 A pending swap SHALL be applied at the clk edge ending row 7, coincident with frame_done; swap_ack pulses in the first cycle of the next row 0, and that row 0 uses the new front.
REQ-024 swap_req in the same cycle as the applying edge SHALL be consumed by that swap, and no second swap SHALL follow.
REQ-025 A write in the same cycle as the applying edge SHALL land in the pre-swap back buffer, which becomes front.
REQ-026 A swap SHALL never alter a row mid-drive; a frame is always displayed from one buffer.

Reset
REQ-027 While reset is high: both buffers = 0, front = buffer 0, pending = 0, row = 0, state = BLANK, cycle count = 0.
REQ-028 While reset is high: row_sel, red_col, green_col, swap_ack and frame_done = 0.
REQ-029 After reset deasserts, the first cycle SHALL be blank cycle 0 of row 0.
REQ-030 Reset mid-frame SHALL abort the frame and discard any pending swap.

Configuration
REQ-031 Macro MATRIX_SCAN_DIM_EN defined: adds input dim[2:0] and a free-running 3-bit PWM counter; in DRIVE, outputs are enabled only while pwm <= dim, and dim=7 gives full brightness.
REQ-032 MATRIX_SCAN_DIM_EN undefined: no dim port and no PWM counter; DRIVE is always full on.

Structure
REQ-033 Package matrix_scan_pkg SHALL hold ROWS=8, COLS=8, the row-index width and the BLANK/DRIVE state typedef.
REQ-034 Sub-module scan_timer SHALL hold the CLK_DIV prescaler and blank counter and emit row_tick and blank signals; buffers and FSM stay in matrix_scan.

Verification (CLK_DIV=4, BLANK_CYC=1)
REQ-035 Reset, then 40 cycles -> all outputs 0; frame_done pulses every 32 cycles, first at cycle 31.
REQ-036 Write row 2 = red 0xA5 / green 0x0F, swap_req, wait for swap_ack -> next frame row 2 drives row_sel=0x04, red=0xA5, green=0x0F for 3 cycles after 1 blank cycle.
REQ-037 Write back buffer without swap -> displayed frame is unchanged and all zeros.
REQ-038 Three swap_req pulses within one frame -> exactly one swap_ack, at the next frame start.
REQ-039 swap_req and write row 0 = 0xFF/0x00 on the row-7 last cycle -> single swap, and row 0 of the next frame shows red 0xFF.
REQ-040 Reset asserted during row 5 DRIVE -> outputs 0 asynchronously and the pending swap is lost; with MATRIX_SCAN_DIM_EN and dim=3, drive is active in 4 of every 8 cycles.
